// File: rtl/out_shift_ctrl_pkg.sv
// out_shift_pkg: shared state type and default geometry for the output shift controller and its bank
package out_shift_pkg;

    typedef enum logic {
        LOAD,
        SHIFT
    } oshift_state_t;

    localparam int OSH_N1 = 76;
    localparam int OSH_N2 = 7;

endpackage

// File: rtl/out_shift_ctrl.sv
// out_shift_ctrl: load/shift sequencer for an N2-lane x N1-bit parallel-load / serial-shift output bank
//   clk_i           : system clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   enable_i        : global run enable, 0 freezes controller and bank
//   flush_i         : synchronous abort of the current frame
//   in_valid_i      : upstream word available on the bank input bus
//   in_ready_o      : a word is accepted this cycle
//   out_ready_i     : downstream consumes the current bit-slice this cycle
//   out_valid_o     : bank outputs hold a valid bit-slice
//   sel_shift_o     : bank control, 1 = shift bits within lanes, 0 = load/shift words
//   sel_keep_o      : bank control, 1 = hold all contents
//   frame_start_o   : current valid slice is the first (MSB) slice of the frame
//   frame_end_o     : current valid slice is the last slice of the frame
//   frame_count_o   : completed frames, wraps modulo 2^FCW
module out_shift_ctrl
    import out_shift_pkg::*;
#(
    parameter int N1  = OSH_N1,
    parameter int N2  = OSH_N2,
    parameter int FCW = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           enable_i,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic           out_ready_i,
    output logic           out_valid_o,
    output logic           sel_shift_o,
    output logic           sel_keep_o,
    output logic           frame_start_o,
    output logic           frame_end_o,
    output logic [FCW-1:0] frame_count_o
);

    localparam int WW = (N2 > 1) ? $clog2(N2) : 1;
    localparam int BW = (N1 > 1) ? $clog2(N1) : 1;
    localparam logic [WW-1:0] WORD_LAST = WW'(N2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N1 - 1);

    oshift_state_t  state_q, state_d;
    logic [WW-1:0]  word_q, word_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           load_fire, shift_fire;

    // in_ready is held low while in reset so the bank is guaranteed to keep its contents
    always_comb begin
        in_ready_o    = rst_ni & (state_q == LOAD) & enable_i & !flush_i;
        out_valid_o   = (state_q == SHIFT) & enable_i & !flush_i;
        load_fire     = in_valid_i & in_ready_o;
        shift_fire    = out_valid_o & out_ready_i;
        sel_shift_o   = (state_q == SHIFT);
        sel_keep_o    = !(load_fire | shift_fire);
        frame_start_o = out_valid_o & (bit_q == '0);
        frame_end_o   = out_valid_o & (bit_q == BIT_LAST);
        frame_count_o = fc_q;
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        fc_d    = fc_q;
        if (flush_i) begin
            state_d = LOAD;
            word_d  = '0;
            bit_d   = '0;
        end else if (load_fire) begin
            word_d  = (word_q == WORD_LAST) ? '0 : word_q + WW'(1);
            bit_d   = (word_q == WORD_LAST) ? '0 : bit_q;
            state_d = (word_q == WORD_LAST) ? SHIFT : LOAD;
        end else if (shift_fire) begin
            bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
            fc_d    = (bit_q == BIT_LAST) ? fc_q + FCW'(1) : fc_q;
            state_d = (bit_q == BIT_LAST) ? LOAD : SHIFT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD;
            word_q  <= '0;
            bit_q   <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            fc_q    <= fc_d;
        end
    end

endmodule

// File: tb/tb_out_shift_ctrl.sv
// tb_out_shift_ctrl: table-driven check of the output shift controller with an attached bank model
module tb_out_shift_ctrl;

    localparam int N1  = 8;
    localparam int N2  = 3;
    localparam int FCW = 4;

    typedef struct {
        logic       en, fl, iv, ordy;
        logic [7:0] w;
        logic       ir, ov, ss, sk, fs, fe;
        logic [3:0] fc;
        logic       cs;
        logic [2:0] sl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, fl = 1'b0, iv = 1'b0, ordy = 1'b0;
    logic [7:0] word = 8'h00;
    logic       ir, ov, ss, sk, fs, fe;
    logic [3:0] fc;
    logic [7:0] lane [3];
    logic [2:0] bank_out;
    logic [3:0] efc = 4'd0;
    int         total = 0;
    int         bad = 0;
    vec_t       tbl[$];

    always #5 clk = ~clk;

    out_shift_ctrl #(.N1(N1), .N2(N2), .FCW(FCW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_i(fl),
        .in_valid_i(iv), .in_ready_o(ir), .out_ready_i(ordy), .out_valid_o(ov),
        .sel_shift_o(ss), .sel_keep_o(sk), .frame_start_o(fs), .frame_end_o(fe),
        .frame_count_o(fc)
    );

    // bank: loads shift words toward lane 0, so the first word of a frame lands in lane 0
    always @(posedge clk) begin
        if (!sk) begin
            if (!ss) begin
                lane[0] <= lane[1];
                lane[1] <= lane[2];
                lane[2] <= word;
            end else begin
                for (int i = 0; i < 3; i++) lane[i] <= lane[i] << 1;
            end
        end
    end
    assign bank_out = {lane[2][7], lane[1][7], lane[0][7]};

    function automatic logic [2:0] sl(input logic [7:0] a, b, c, input int k);
        return {c[7-k], b[7-k], a[7-k]};
    endfunction

    function automatic vec_t r(input logic e, f, v, o, input logic [7:0] w,
                               input logic i_r, o_v, s_s, s_k, f_s, f_e,
                               input logic [3:0] c, input logic cs, input logic [2:0] s);
        vec_t x;
        x.en = e; x.fl = f; x.iv = v; x.ordy = o; x.w = w;
        x.ir = i_r; x.ov = o_v; x.ss = s_s; x.sk = s_k; x.fs = f_s; x.fe = f_e;
        x.fc = c; x.cs = cs; x.sl = s;
        return x;
    endfunction

    function automatic vec_t idle(input logic [3:0] c);
        return r(1, 0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 0, c, 0, 3'b000);
    endfunction

    function automatic vec_t ld(input logic [7:0] w, input logic [3:0] c);
        return r(1, 0, 1, 1, w, 1, 0, 0, 0, 0, 0, c, 0, 3'b000);
    endfunction

    function automatic vec_t sh(input int k, input logic rdy, input logic [3:0] c,
                                input logic [7:0] a, b, d);
        return r(1, 0, 0, rdy, 8'h00, 0, 1, 1, !rdy, k == 0, k == 7, c, 1, sl(a, b, d, k));
    endfunction

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic apply(input vec_t v, input string n);
        @(negedge clk);
        en = v.en; fl = v.fl; iv = v.iv; ordy = v.ordy; word = v.w;
        #1;
        chk({n, ".in_ready"}, {7'd0, ir}, {7'd0, v.ir});
        chk({n, ".out_valid"}, {7'd0, ov}, {7'd0, v.ov});
        chk({n, ".sel_shift"}, {7'd0, ss}, {7'd0, v.ss});
        chk({n, ".sel_keep"}, {7'd0, sk}, {7'd0, v.sk});
        chk({n, ".frame_start"}, {7'd0, fs}, {7'd0, v.fs});
        chk({n, ".frame_end"}, {7'd0, fe}, {7'd0, v.fe});
        chk({n, ".frame_count"}, {4'd0, fc}, {4'd0, v.fc});
        if (v.cs) chk({n, ".slice"}, {5'd0, bank_out}, {5'd0, v.sl});
    endtask

    // gap: idle cycles before word j = gap*j; stall: refused cycles before each slice after the first
    task automatic add_frame(input logic [7:0] a, b, c, input int gap, input int stall,
                             input logic [3:0] f);
        logic [7:0] ws [3];
        ws[0] = a; ws[1] = b; ws[2] = c;
        for (int j = 0; j < 3; j++) begin
            for (int g = 0; g < gap * j; g++) tbl.push_back(idle(f));
            tbl.push_back(ld(ws[j], f));
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) for (int s = 0; s < stall; s++) tbl.push_back(sh(k, 0, f, a, b, c));
            tbl.push_back(sh(k, 1, f, a, b, c));
        end
        tbl.push_back(idle(f + 4'd1));
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s%0d", tag, i));
        tbl.delete();
    endtask

    task automatic rst_chk(input string n);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; iv = 1'b1; ordy = 1'b1;
        #1;
        chk({n, ".in_ready"}, {7'd0, ir}, 8'd0);
        chk({n, ".out_valid"}, {7'd0, ov}, 8'd0);
        chk({n, ".sel_shift"}, {7'd0, ss}, 8'd0);
        chk({n, ".sel_keep"}, {7'd0, sk}, 8'd1);
        chk({n, ".frame_start"}, {7'd0, fs}, 8'd0);
        chk({n, ".frame_end"}, {7'd0, fe}, 8'd0);
        chk({n, ".frame_count"}, {4'd0, fc}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1; iv = 1'b0;
        efc = 4'd0;
    endtask

    initial begin
        add_frame(8'hA5, 8'h3C, 8'hF0, 0, 0, 4'd0);
        add_frame(8'hA5, 8'h3C, 8'hF0, 0, 2, 4'd1);
        add_frame(8'h81, 8'h7E, 8'h55, 1, 0, 4'd2);

        rst_chk("reset");
        run_tbl("tbl");
        efc = 4'd3;

        // flush at BitCnt=4, then an intact frame
        for (int j = 0; j < 3; j++) apply(ld(8'h12 + 8'(j * 8'h31), efc), "fl_ld");
        for (int k = 0; k < 4; k++) apply(sh(k, 1, efc, 8'h12, 8'h43, 8'h74), "fl_sh");
        apply(r(1, 1, 1, 1, 8'h00, 0, 0, 1, 1, 0, 0, efc, 0, 3'b000), "fl_cyc");
        apply(idle(efc), "fl_after");
        add_frame(8'hC3, 8'h0F, 8'h96, 0, 0, efc);
        run_tbl("fl_frame");
        efc = efc + 4'd1;

        // enable low for five cycles at BitCnt=2, bank must hold slice 2
        for (int j = 0; j < 3; j++) apply(ld(8'hE1 - 8'(j * 8'h22), efc), "en_ld");
        for (int k = 0; k < 2; k++) apply(sh(k, 1, efc, 8'hE1, 8'hBF, 8'h9D), "en_sh");
        for (int c = 0; c < 5; c++)
            apply(r(0, 0, 1, 1, 8'hFF, 0, 0, 1, 1, 0, 0, efc, 1, sl(8'hE1, 8'hBF, 8'h9D, 2)), "en_off");
        for (int k = 2; k < 8; k++) apply(sh(k, 1, efc, 8'hE1, 8'hBF, 8'h9D), "en_resume");
        efc = efc + 4'd1;
        apply(idle(efc), "en_done");

        // reset mid-LOAD then mid-SHIFT, then full frame
        apply(ld(8'h11, efc), "rl_ld");
        apply(ld(8'h22, efc), "rl_ld");
        rst_chk("rst_load");
        apply(idle(efc), "rl_after");
        for (int j = 0; j < 3; j++) apply(ld(8'h5A, efc), "rs_ld");
        for (int k = 0; k < 3; k++) apply(sh(k, 1, efc, 8'h5A, 8'h5A, 8'h5A), "rs_sh");
        rst_chk("rst_shift");
        add_frame(8'h69, 8'hD2, 8'h1E, 0, 0, efc);
        run_tbl("rs_frame");
        efc = 4'd1;

        // sixteen more frames: count passes 15 -> 0 and ends at 1
        for (int f = 0; f < 16; f++) begin
            add_frame(8'(f * 8'h11), 8'(8'hFF - f), 8'(f * 8'h07 + 8'h3), 0, 0, efc);
            run_tbl($sformatf("wrap%0d_", f));
            efc = efc + 4'd1;
        end
        chk("wrap_final", {4'd0, fc}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_shift_ctrl.md
Name: out_shift_ctrl

Overview:
- Sequencer for the parallel-load / serial-shift output register bank: N2 lanes, each N1 bits wide.
- Accepts N2 parallel words over a valid/ready handshake, driving load mode for each word.
- Then switches to shift mode and emits N1 bit-slices across all N2 lanes, one per cycle, under downstream backpressure.
- Drives the bank's SelShift/SelKeep controls and the frame framing/status signals toward the output interface.

Parameters:
- N1, 76, lane width in bits = shift cycles per frame
- N2, 7, number of lanes = load cycles per frame
- FCW, 16, width of completed-frame counter

Ports:
- Clock  input  1  system clock, rising edge
- nReset  input  1  asynchronous active-low reset
- Enable  input  1  global run enable; 0 freezes controller and bank
- Flush  input  1  synchronous abort of current frame
- InValid  input  1  upstream word available on the bank's In bus
- InReady  output  1  controller accepts a word this cycle
- OutReady  input  1  downstream consumes current bit-slice this cycle
- OutValid  output  1  bank outputs hold a valid bit-slice
- SelShift  output  1  bank control: 1 = shift bits within lanes, 0 = load/shift words
- SelKeep  output  1  bank control: 1 = hold all contents
- FrameStart  output  1  current valid slice is bit 0 (MSB) of the frame
- FrameEnd  output  1  current valid slice is the last bit of the frame
- FrameCount  output  FCW  completed frames, wraps modulo 2^FCW

Behaviour:
- State register: LOAD, SHIFT.
- Counters: WordCnt (width max(1,$clog2(N2))) and BitCnt (width max(1,$clog2(N1))).
- Async reset: state=LOAD, WordCnt=0, BitCnt=0, FrameCount=0. During reset: OutValid=0, SelShift=0, SelKeep=1, FrameStart=0, FrameEnd=0.
- All outputs except FrameCount are combinational from state, counters, Enable, Flush and the handshakes.
- Definitions:
  - load_fire = InValid & InReady
  - shift_fire = OutValid & OutReady
- InReady = (state==LOAD) & Enable & !Flush.
- OutValid = (state==SHIFT) & Enable & !Flush.
- SelShift = (state==SHIFT).
- SelKeep = !(load_fire | shift_fire). The bank must never change except on a fire.
- LOAD state:
  - On each load_fire, WordCnt increments.
  - On the load_fire with WordCnt==N2-1: WordCnt←0, BitCnt←0, state←SHIFT.
  - The first word loaded ends up in lane 0. The bank's bit N1-1 of every lane is valid on the cycle after the final load_fire; there is no bubble.
- SHIFT state:
  - On each shift_fire, BitCnt increments.
  - On the shift_fire with BitCnt==N1-1: BitCnt←0, FrameCount←FrameCount+1, state←LOAD.
  - Total cost is N2 + N1 cycles per frame at full throughput (83 at default).
- FrameStart = OutValid & (BitCnt==0). FrameEnd = OutValid & (BitCnt==N1-1). Both are asserted together when N1==1.
- Backpressure:
  - OutReady=0 in SHIFT → SelKeep=1; slice and counters hold.
  - InValid=0 in LOAD → SelKeep=1; partial frame is retained.
- Enable=0: InReady=0, OutValid=0, SelKeep=1; state and counters hold. Resumes exactly where it left off.
- Flush=1 (priority over all fires):
  - Next state=LOAD, WordCnt←0, BitCnt←0, FrameCount unchanged.
  - Same cycle: SelKeep=1, InReady=0, OutValid=0.
  - Stale bank contents are overwritten by the next N2 loads.
- N2==1: one load_fire goes directly to SHIFT.
- FrameCount wraps 2^FCW-1 → 0 silently.

Decomposition:
- Shared package out_shift_pkg:
  - typedef enum logic {LOAD, SHIFT} oshift_state_t.
  - Default N1/N2 localparams, shared with the bank instance.
- No sub-module: a single FSM with two counters.
- The integration wrapper instantiates this block next to the bank, passing identical N1/N2.

Test Plan (N1=8, N2=3, FCW=4 unless noted; bank model attached):
- Back-to-back: InValid=1 with words 0xA5, 0x3C, 0xF0, OutReady=1.
  - InReady high 3 cycles, then OutValid high 8 cycles.
  - Out lanes {0:0xA5, 1:0x3C, 2:0xF0} emitted MSB-first.
  - FrameStart on slice 0, FrameEnd on slice 7, FrameCount 0→1, InReady returns next cycle.
- Backpressure: OutReady toggles 1,0,0,1… during SHIFT.
  - SelKeep=1 and Out stable on every OutReady=0 cycle.
  - Exactly 8 shift_fires per frame; data matches the first test.
- Input gaps: InValid pattern 1,0,1,0,0,1.
  - WordCnt advances only on fires; SHIFT entered the cycle after the third fire; correct lane order.
- Flush at BitCnt=4: next cycle state=LOAD, counters 0, FrameCount unchanged.
  - Following 3-word frame is emitted intact.
- Reset mid-LOAD (after 2 words) and mid-SHIFT: outputs take their reset values immediately.
  - After release, InReady=1 and a full frame completes with FrameCount=1.
- Enable=0 for 5 cycles at BitCnt=2, then 1: no bank change while low.
  - Emission resumes at slice 2; a run of 17 frames shows FrameCount wrapping 15→0.
